data_mem_responder: RTL and testbench

//   Memory-side responder for the CPU load/store path. Accepts one request at a time from the

---
 rtl/data_mem_responder_pkg.sv | 37 +++
 rtl/data_mem_responder_if.sv | 33 +++
 rtl/data_mem_responder_be_gen.sv | 35 +++
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 tb/tb_data_mem_responder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// datamem_pkg: shared types and helpers for the data memory responder and
// any future cache front-end that reuses the byte-enable generator.
//   size_e       funct3 access-size codes carried on req_size
//   state_e      responder FSM states
//   legal_access size legality (per direction) combined with natural alignment
package datamem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Unsigned variants only make sense for loads; stores accept b/h/w.
    function automatic bit legal_access(input logic we, input logic [2:0] size,
                                        input logic [1:0] addr_lo);
        bit ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = !addr_lo[0];
            SZ_W:    ok = (addr_lo == 2'b00);
            SZ_BU:   ok = !we;
            SZ_HU:   ok = !we && !addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bus between the load/store data
// controller (master) and the data memory responder (slave).
//   req_valid/req_ready  request handshake
//   req_we, req_size, req_addr, req_wdata  request payload
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata, rsp_err   response payload
//   busy                 responder has a request outstanding
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_size;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  busy;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/data_mem_responder_be_gen.sv
// datamem_be_gen: combinational byte-enable and misalignment decode.
//   size     in  funct3 size code
//   addr_lo  in  byte address bits [1:0]
//   we       in  store flag; enables are forced to zero for loads
//   be       out per-lane write enables
//   misalign out half not on a 2-byte boundary, or word not on a 4-byte boundary
module datamem_be_gen
    import datamem_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    input  logic       we,
    output logic [3:0] be,
    output logic       misalign
);

    always_comb begin
        be       = 4'b0000;
        misalign = 1'b0;
        case (size)
            SZ_B, SZ_BU: be = 4'b0001 << addr_lo;
            SZ_H, SZ_HU: begin
                be       = 4'b0011 << {addr_lo[1], 1'b0};
                misalign = addr_lo[0];
            end
            SZ_W: begin
                be       = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default: ;
        endcase
        if (!we) be = 4'b0000;
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the CPU load/store path.
// Accepts one request at a time, waits a fixed LATENCY, then commits the
// store (byte-lane masked) or captures the full aligned word for a load,
// and holds the response until it is consumed.
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   bus   slave side of data_mem_responder_if
//
// state | meaning
// IDLE  | ready for a request; accept edge latches the request
// WAIT  | latency down-counter running; count==1 edge commits
// RESP  | response held on rsp_* until rsp_ready
module data_mem_responder
    import datamem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_WIDTH-3:0] WORDS_LIMIT = (ADDR_WIDTH-2)'(MEM_WORDS);

    if (LATENCY < 1) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be >= 1");
    end
    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("data_mem_responder: DATA_WIDTH must be 32");
    end

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      count_q;
    logic                  lat_we;
    logic [2:0]            lat_size;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // With LATENCY==1 the commit happens on the accept edge itself, so the
    // commit path reads the live request when idle and the latched copy otherwise.
    logic                  cur_we;
    logic [2:0]            cur_size;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [ADDR_WIDTH-3:0] word_addr;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            be;
    logic                  misalign;
    logic                  access_err;
    logic                  accept;
    logic                  commit;

    assign cur_we    = (state_q == IDLE) ? bus.req_we    : lat_we;
    assign cur_size  = (state_q == IDLE) ? bus.req_size  : lat_size;
    assign cur_addr  = (state_q == IDLE) ? bus.req_addr  : lat_addr;
    assign cur_wdata = (state_q == IDLE) ? bus.req_wdata : lat_wdata;
    assign word_addr = cur_addr[ADDR_WIDTH-1:2];
    assign idx       = word_addr[IDX_W-1:0];

    datamem_be_gen u_be_gen (
        .size     (cur_size),
        .addr_lo  (cur_addr[1:0]),
        .we       (cur_we),
        .be       (be),
        .misalign (misalign)
    );

    assign access_err = !legal_access(cur_we, cur_size, cur_addr[1:0]) || misalign
                        || (word_addr >= WORDS_LIMIT);
    assign accept     = (state_q == IDLE) && bus.req_valid;
    assign commit     = (accept && (LATENCY == 1))
                        || ((state_q == WAIT) && (count_q == CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.req_valid) state_d = (LATENCY == 1) ? RESP : WAIT;
            WAIT: if (count_q == CNT_W'(1)) state_d = RESP;
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            lat_we    <= 1'b0;
            lat_size  <= 3'b000;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            count_q   <= CNT_W'(LATENCY - 1);
            lat_we    <= bus.req_we;
            lat_size  <= bus.req_size;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
        end else if (state_q == WAIT) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (commit) begin
            rsp_err_q   <= access_err;
            rsp_rdata_q <= (!access_err && !cur_we) ? mem[idx] : '0;
        end
    end

    // Array is deliberately not reset; a commit coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && commit && cur_we && !access_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    import datamem_pkg::*;

    localparam int MW  = 64;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_tp;

    data_mem_responder_if bus  ();
    data_mem_responder_if bus1 ();
    data_mem_responder_if bus4 ();

    data_mem_responder #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave));
    data_mem_responder #(.MEM_WORDS(16), .LATENCY(1)) dut1 (
        .clk (clk), .rst (rst_tp), .bus (bus1.slave));
    data_mem_responder #(.MEM_WORDS(16), .LATENCY(4)) dut4 (
        .clk (clk), .rst (rst_tp), .bus (bus4.slave));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    // Reference model: plain word array with byte arithmetic.
    logic [31:0] ref_mem [MW];

    function automatic void model(input logic we, input logic [2:0] size,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic err, output logic [31:0] rdata);
        int nbytes;
        int off;
        logic [31:0] word;
        case (size)
            3'd0, 3'd4: nbytes = 1;
            3'd1, 3'd5: nbytes = 2;
            3'd2:       nbytes = 4;
            default:    nbytes = 0;
        endcase
        word = addr / 4;
        off  = int'(addr % 4);
        err  = (nbytes == 0) || (we && size > 3'd2) || ((off % ((nbytes == 0) ? 1 : nbytes)) != 0)
               || (word >= MW);
        rdata = 32'h0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (b >= off && b < off + nbytes)
                        ref_mem[word[5:0]][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rdata = ref_mem[word[5:0]];
            end
        end
    endfunction

    task automatic txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input int stall, input string tag);
        logic e_err;
        logic [31:0] e_rd;
        int n;
        model(we, size, addr, wdata, e_err, e_rd);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        n = 0;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus.req_ready) chk({tag, " accept timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
        chk({tag, " latency"}, n, LAT);
        chk({tag, " err"}, {31'b0, bus.rsp_err}, {31'b0, e_err});
        chk({tag, " rdata"}, bus.rsp_rdata, e_rd);
        if (stall > 0) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_size  = 3'b010;
            bus.req_addr  = 32'h4;
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                chk({tag, " stall valid"}, {31'b0, bus.rsp_valid}, 32'd1);
                chk({tag, " stall rdata"}, bus.rsp_rdata, e_rd);
                chk({tag, " stall busy"}, {31'b0, bus.busy}, 32'd1);
                chk({tag, " stall ready"}, {31'b0, bus.req_ready}, 32'd0);
            end
            bus.req_valid = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, " rsp_valid clear"}, {31'b0, bus.rsp_valid}, 32'd0);
        chk({tag, " idle ready"}, {31'b0, bus.req_ready}, 32'd1);
    endtask

    task automatic tp_step(input int lat, input logic rv, input logic rr, input logic vv,
                           input int cyc, input string tag,
                           inout int last_acc, inout logic prev_v, inout int n_acc);
        if (vv && !prev_v && last_acc >= 0)
            chk({tag, " accept->valid"}, cyc - last_acc, lat);
        if (rv && rr) begin
            if (last_acc >= 0) chk({tag, " period"}, cyc - last_acc, lat + 1);
            last_acc = cyc;
            n_acc++;
        end
        prev_v = vv;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e_err;
        logic [31:0] e_rd, a, d;
        logic we;
        logic [2:0] sz;
        int last1, last4, acc1, acc4;
        logic pv1, pv4;

        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_addr = 0;
        bus.req_wdata = 0; bus.rsp_ready = 0;
        bus1.req_valid = 0; bus1.req_we = 0; bus1.req_size = 3'b010; bus1.req_addr = 0;
        bus1.req_wdata = 0; bus1.rsp_ready = 1;
        bus4.req_valid = 0; bus4.req_we = 0; bus4.req_size = 3'b010; bus4.req_addr = 0;
        bus4.req_wdata = 0; bus4.rsp_ready = 1;
        rst = 1; rst_tp = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0; rst_tp = 0;

        chk("reset req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("reset busy", {31'b0, bus.busy}, 32'd0);
        chk("reset rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("reset rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("reset rsp_err", {31'b0, bus.rsp_err}, 32'd0);

        // Back-to-back loads on LATENCY=1 and LATENCY=4 instances.
        last1 = -1; last4 = -1; acc1 = 0; acc4 = 0; pv1 = 0; pv4 = 0;
        bus1.req_valid = 1; bus4.req_valid = 1;
        for (int c = 0; c < 60; c++) begin
            tp_step(1, bus1.req_valid, bus1.req_ready, bus1.rsp_valid, c, "L1", last1, pv1, acc1);
            tp_step(4, bus4.req_valid, bus4.req_ready, bus4.rsp_valid, c, "L4", last4, pv4, acc4);
            @(negedge clk);
        end
        bus1.req_valid = 0; bus4.req_valid = 0;
        chk("L1 throughput", {31'b0, acc1 >= 29}, 32'd1);
        chk("L4 throughput", {31'b0, acc4 >= 11}, 32'd1);

        for (int w = 0; w < MW; w++) txn(1, SZ_W, 32'(w * 4), $urandom, 0, "fill");

        txn(1, SZ_W, 32'h10, 32'hDEADBEEF, 0, "t1 sw");
        txn(0, SZ_W, 32'h10, 32'h0, 0, "t1 lw");
        chk("t1 model", ref_mem[4], 32'hDEADBEEF);
        txn(1, SZ_B, 32'h12, 32'h00AA0000, 0, "t2 sb");
        txn(0, SZ_W, 32'h10, 32'h0, 0, "t2 lw sb");
        txn(1, SZ_H, 32'h10, 32'h00001234, 0, "t2 sh");
        txn(0, SZ_W, 32'h10, 32'h0, 0, "t2 lw sh");
        chk("t2 model", ref_mem[4], 32'hDEAA1234);

        txn(0, SZ_H, 32'h11, 32'h0, 0, "t3 lh misalign");
        txn(1, SZ_W, 32'h22, 32'h55555555, 0, "t3 sw misalign");
        txn(0, SZ_W, 32'h20, 32'h0, 0, "t3 lw unchanged");
        txn(1, SZ_BU, 32'h40, 32'h12345678, 0, "t3 store bu");
        txn(0, SZ_W, 32'h40, 32'h0, 0, "t3 lw after bu");
        txn(0, SZ_W, 32'(4 * MW), 32'h0, 0, "t3 lw range");
        txn(0, 3'b011, 32'h0, 32'h0, 0, "t3 size 011");

        txn(0, SZ_W, 32'h10, 32'h0, 5, "t4 stall");

        // Reset while the store sits in WAIT (its commit edge sees rst=1).
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = 1; bus.req_size = SZ_W;
        bus.req_addr = 32'h30; bus.req_wdata = 32'h11111111;
        @(posedge clk);
        #1 bus.req_valid = 0;
        @(negedge clk);
        chk("t6 in wait", {31'b0, bus.busy}, 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("t6 busy after rst", {31'b0, bus.busy}, 32'd0);
        chk("t6 rsp_valid after rst", {31'b0, bus.rsp_valid}, 32'd0);
        txn(0, SZ_W, 32'h30, 32'h0, 0, "t6 lw prior");

        for (int r = 0; r < 200; r++) begin
            we = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = 32'(4 * MW + $urandom_range(0, 255));
            else a = 32'($urandom_range(0, 4 * MW - 1));
            d = $urandom;
            txn(we, sz, a, d, 0, "rand");
        end
        model(0, SZ_W, 32'h10, 32'h0, e_err, e_rd);
        txn(0, SZ_W, 32'h10, 32'h0, 0, "final lw");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
